// File: rtl/calc_seq_engine.sv
// rtl/calc_seq_engine.sv - multi-cycle BCD calculator: digit conversion, then add/sub/shift-add mul/restoring div
module calc_seq_engine #(
    parameter int NDIG = 2,
    parameter int OPW  = 7,
    parameter int RW   = 14,
    parameter logic [7:0] A_add  = 8'h0A,
    parameter logic [7:0] B_sub  = 8'h0B,
    parameter logic [7:0] f_mult = 8'h0F,
    parameter logic [7:0] D_ivid = 8'h0D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        op,
    input  logic [4*NDIG-1:0] a_bcd,
    input  logic [4*NDIG-1:0] b_bcd,
    output logic              busy,
    output logic              done,
    output logic [RW-1:0]     result,
    output logic [OPW-1:0]    rem,
    output logic              neg,
    output logic              err
);
    localparam int CW = $clog2(OPW + NDIG + 1);

    typedef enum logic [1:0] {IDLE, CONV, EXEC, DONE} state_t;
    state_t state, state_nx;

    logic [7:0]        op_r;
    logic [4*NDIG-1:0] a_sh, b_sh;
    logic [OPW-1:0]    acc_a, acc_b, work, part;
    logic [RW-1:0]     prod, mcand;
    logic [CW-1:0]     cnt;
    logic              bad;

    logic [3:0]     dig_a, dig_b;
    logic [OPW-1:0] acc_a_nx, acc_b_nx;
    logic           bad_nx, op_ok, conv_last, exec_last, conv_err;
    logic [RW-1:0]  prod_step;
    logic [OPW:0]   shifted, trial;
    logic [OPW-1:0] part_step, work_div, work_mul;

    assign dig_a     = a_sh[4*NDIG-1 -: 4];
    assign dig_b     = b_sh[4*NDIG-1 -: 4];
    assign acc_a_nx  = acc_a * OPW'(10) + OPW'(dig_a);
    assign acc_b_nx  = acc_b * OPW'(10) + OPW'(dig_b);
    assign bad_nx    = bad | (dig_a > 4'd9) | (dig_b > 4'd9);
    assign op_ok     = (op_r == A_add) || (op_r == B_sub) || (op_r == f_mult) || (op_r == D_ivid);
    assign conv_last = (cnt == CW'(NDIG - 1));
    assign exec_last = (op_r == A_add) || (op_r == B_sub) || (cnt == CW'(OPW - 1));
    assign conv_err  = bad_nx || !op_ok || ((op_r == D_ivid) && (acc_b_nx == '0));

    // One iteration of each multi-cycle algorithm; work holds the multiplier or the dividend/quotient.
    assign prod_step = work[0] ? prod + mcand : prod;
    assign work_mul  = work >> 1;
    assign shifted   = {part, work[OPW-1]};
    assign trial     = shifted - {1'b0, acc_b};
    assign part_step = trial[OPW] ? shifted[OPW-1:0] : trial[OPW-1:0];
    assign work_div  = {work[OPW-2:0], ~trial[OPW]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: if (start) state_nx = CONV;
            CONV: if (conv_last) state_nx = conv_err ? DONE : EXEC;
            EXEC: if (exec_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r <= '0; a_sh <= '0; b_sh <= '0;
            acc_a <= '0; acc_b <= '0; work <= '0; part <= '0;
            prod <= '0; mcand <= '0; cnt <= '0; bad <= 1'b0;
            result <= '0; rem <= '0; neg <= 1'b0; err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r  <= op;
                    a_sh  <= a_bcd;
                    b_sh  <= b_bcd;
                    acc_a <= '0;
                    acc_b <= '0;
                    bad   <= 1'b0;
                    cnt   <= '0;
                end
                CONV: begin
                    a_sh  <= a_sh << 4;
                    b_sh  <= b_sh << 4;
                    acc_a <= acc_a_nx;
                    acc_b <= acc_b_nx;
                    bad   <= bad_nx;
                    cnt   <= conv_last ? '0 : cnt + 1'b1;
                    if (conv_last) begin
                        prod  <= '0;
                        mcand <= RW'(acc_b_nx);
                        work  <= acc_a_nx;
                        part  <= '0;
                    end
                    if (conv_last && conv_err) begin
                        result <= '0;
                        rem    <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt   <= cnt + 1'b1;
                    prod  <= prod_step;
                    mcand <= mcand << 1;
                    if (op_r == D_ivid) begin
                        work <= work_div;
                        part <= part_step;
                    end else begin
                        work <= work_mul;
                    end
                    if (exec_last) begin
                        err <= 1'b0;
                        rem <= '0;
                        neg <= 1'b0;
                        if (op_r == A_add) begin
                            result <= RW'(acc_a) + RW'(acc_b);
                        end else if (op_r == B_sub) begin
                            result <= (acc_a >= acc_b) ? RW'(acc_a - acc_b) : RW'(acc_b - acc_a);
                            neg    <= (acc_a < acc_b);
                        end else if (op_r == f_mult) begin
                            result <= prod_step;
                        end else begin
                            result <= RW'(work_div);
                            rem    <= part_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
